word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 97 +++++++++
 tb/tb_word_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// 32-bit word to serial bit stream with start/busy/done framing and a valid/ready load handshake.
// Optional build macro WORD_SERIALIZER_LSB_FIRST_EN selects LSB-first order (default MSB-first).
module word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] data_in,
  output logic        start,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [31:0] shreg_q;
  logic [4:0]  cnt_q;

  logic [31:0] shreg_shifted;
  logic        next_bit;
  logic        first_bit;

  // dout always shows the bit at the head of the register; next_bit is the one behind it.
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
  assign shreg_shifted = {1'b0, shreg_q[31:1]};
  assign next_bit      = shreg_q[1];
  assign first_bit     = data_in[0];
`else
  assign shreg_shifted = {shreg_q[30:0], 1'b0};
  assign next_bit      = shreg_q[30];
  assign first_bit     = data_in[31];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      load_ready <= 1'b1;
      start      <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q    <= START;
            shreg_q    <= data_in;
            cnt_q      <= '0;
            load_ready <= 1'b0;
            start      <= 1'b1;
            busy       <= 1'b1;
            dout       <= first_bit;
          end
        end
        START: begin
          state_q <= SHIFT;
          start   <= 1'b0;
          cnt_q   <= cnt_q + 5'd1;
          shreg_q <= shreg_shifted;
          dout    <= next_bit;
        end
        SHIFT: begin
          // Counter wraps 31->0 exactly as the 32nd bit leaves the line.
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dout    <= 1'b0;
            shreg_q <= '0;
          end else begin
            shreg_q <= shreg_shifted;
            dout    <= next_bit;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          load_ready <= 1'b1;
          start      <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          dout       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: table-driven frames, a word scoreboard, and
// hand-written sequences for ignored loads, mid-frame reset and back-to-back frames.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] data_in;
  logic        start;
  logic        dout;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] w;
    logic        first_msb;
    logic        first_lsb;
  } vec_t;

  vec_t vecs[5];

  word_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .start      (start),
    .dout       (dout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input int k);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w[k-1];
`else
    return w[32-k];
`endif
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (load_ready === 1'b1) return;
      @(negedge clk);
    end
    chk("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // Drives one word, then checks every output for cycles 1..34 after acceptance.
  // Ends at the negedge of cycle 34 (load_ready expected high).
  task automatic do_frame(input logic [31:0] w, input logic first, input bit keep_valid,
                          input logic [31:0] nxt, input int inj_cycle, input logic [31:0] inj_data);
    logic [31:0] got;
    logic [31:0] exp_w;
    got = '0;
    wait_ready();
    load_valid = 1'b1;
    data_in    = w;
    exp_q.push_back(w);
    @(negedge clk);
    if (keep_valid) data_in = nxt;
    else load_valid = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("start w=%h k=%0d", w, k), start, (k == 1));
      chk($sformatf("busy w=%h k=%0d", w, k), busy, (k >= 1 && k <= 32));
      chk($sformatf("done w=%h k=%0d", w, k), done, (k == 33));
      chk($sformatf("load_ready w=%h k=%0d", w, k), load_ready, (k == 34));
      chk($sformatf("dout w=%h k=%0d", w, k), dout, (k <= 32) ? exp_bit(w, k) : 1'b0);
      if (start && done) chk("start_and_done", 32'd1, 32'd0);
      if (k == 1) chk($sformatf("first_bit w=%h", w), dout, first);
      if (k <= 32) begin
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
        got = {dout, got[31:1]};
`else
        got = {got[30:0], dout};
`endif
      end
      if (k == 32) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else begin
          exp_w = exp_q.pop_front();
          chk("frame_word", got, exp_w);
        end
      end
      if (inj_cycle != 0 && k == inj_cycle) begin
        load_valid = 1'b1;
        data_in    = inj_data;
      end
      if (inj_cycle != 0 && k == inj_cycle + 1) load_valid = 1'b0;
      if (k < 34) @(negedge clk);
    end
    $display("frame w=%h collected=%h checks=%0d failures=%0d", w, got, checks, failures);
  endtask

  initial begin
    vecs[0] = '{32'hAAAA_AAAA, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0001, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 1'b0, 1'b0};
    vecs[4] = '{32'hDEAD_BEEF, 1'b1, 1'b1};

    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    // Reset state, with a handshake attempted while rst is high.
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 1'b0);
    load_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    chk("post_rst_no_start", start, 1'b0);
    chk("post_rst_ready", load_ready, 1'b1);
    $display("reset sequence checks=%0d failures=%0d", checks, failures);

    for (int i = 0; i < 5; i++) begin
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
      do_frame(vecs[i].w, vecs[i].first_lsb, 1'b0, 32'd0, 0, 32'd0);
`else
      do_frame(vecs[i].w, vecs[i].first_msb, 1'b0, 32'd0, 0, 32'd0);
`endif
    end

    // Load attempt in cycle 10 of an active frame must be dropped.
    do_frame(32'h0000_0000, 1'b0, 1'b0, 32'd0, 10, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_second_start c=%0d", i), start, 1'b0);
      chk($sformatf("idle_busy c=%0d", i), busy, 1'b0);
    end
    chk("ignored_word_not_queued", exp_q.size(), 32'd0);

    // Reset in cycle 15 of a frame aborts it asynchronously, with no done pulse.
    wait_ready();
    load_valid = 1'b1;
    data_in    = 32'h1234_5678;
    @(negedge clk);
    load_valid = 1'b0;
    chk("abort_frame_started", start, 1'b1);
    repeat (14) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_start", start, 1'b0);
    chk("abort_dout", dout, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_load_ready", load_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done c=%0d", i), done, 1'b0);
      chk($sformatf("abort_idle_ready c=%0d", i), load_ready, 1'b1);
    end
    $display("abort sequence checks=%0d failures=%0d", checks, failures);
    do_frame(32'hF0F0_F0F0, 1'b0 ^ exp_bit(32'hF0F0_F0F0, 1) ^ 1'b0, 1'b0, 32'd0, 0, 32'd0);

    // load_valid held high: frames back to back at 34-cycle spacing.
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    do_frame(32'h0000_FFFF, 1'b1, 1'b1, 32'h5555_5555, 0, 32'd0);
    do_frame(32'h5555_5555, 1'b1, 1'b0, 32'd0, 0, 32'd0);
`else
    do_frame(32'h0000_FFFF, 1'b0, 1'b1, 32'h5555_5555, 0, 32'd0);
    do_frame(32'h5555_5555, 1'b0, 1'b0, 32'd0, 0, 32'd0);
`endif
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
